// File: rtl/sat_sub_pipe_pkg.sv
// rtl/sat_sub_pipe_pkg.sv - shared ALU constants and stage-1 payload type for sat_sub_pipe
package sat_sub_pipe_pkg;

   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8000;

   // Flag bit positions, common to the saturating adder and the flag register
   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int NFLAGS = 3;

   typedef logic [NFLAGS-1:0] flags_t;

   typedef struct packed {
      logic [7:0] lo;
      logic       c8;
      logic [7:0] a_hi;
      logic [7:0] nb_hi;
   } s1_t;

endpackage

// File: rtl/sat_sub_pipe_cla4.sv
// rtl/sat_sub_pipe_cla4.sv - 4-bit carry-lookahead adder slice
module cla_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   assign c[0] = c_i;
   assign c[1] = g[0] | (p[0] & c_i);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c_i);

   assign s_o = p ^ c[3:0];
   assign c_o = c[4];

endmodule

// File: rtl/sat_sub_pipe_sub8.sv
// rtl/sat_sub_pipe_sub8.sv - 8-bit a + nb + cin from two CLA slices with ripple carry between them
module sub_8bit (
   input  logic [7:0] a_i,
   input  logic [7:0] nb_i,
   input  logic       c_i,
   output logic [7:0] s_o,
   output logic       c_o
);

   logic c4;

   cla_4bit u_cla_lo (
      .a_i (a_i[3:0]),
      .b_i (nb_i[3:0]),
      .c_i (c_i),
      .s_o (s_o[3:0]),
      .c_o (c4)
   );

   cla_4bit u_cla_hi (
      .a_i (a_i[7:4]),
      .b_i (nb_i[7:4]),
      .c_i (c4),
      .s_o (s_o[7:4]),
      .c_o (c_o)
   );

endmodule

// File: rtl/sat_sub_pipe.sv
// rtl/sat_sub_pipe.sv - two-stage pipelined 16-bit saturating subtractor with N/Z/V flags
module sat_sub_pipe
   import sat_sub_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] diff,
   output logic        ovfl,
   output logic        neg,
   output logic        zero
);

   logic        s1_valid_q, s1_valid_d;
   s1_t         s1_q, s1_d;
   logic        s2_valid_q, s2_valid_d;
   logic [15:0] diff_q, diff_d;
   flags_t      flags_q, flags_d;

   logic        advance;
   logic [7:0]  lo_sum;
   logic        lo_c8;
   logic [7:0]  hi_sum;
   logic        c16_unused;
   logic [15:0] raw;
   logic        a15, b15, ovfl_raw;
   logic [15:0] sat;

   assign advance  = !s2_valid_q | out_ready;
   assign in_ready = !s1_valid_q | !s2_valid_q | out_ready;

   sub_8bit u_sub_lo (
      .a_i  (a[7:0]),
      .nb_i (~b[7:0]),
      .c_i  (1'b1),
      .s_o  (lo_sum),
      .c_o  (lo_c8)
   );

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.lo    = lo_sum;
            s1_d.c8    = lo_c8;
            s1_d.a_hi  = a[15:8];
            s1_d.nb_hi = ~b[15:8];
         end
      end
   end

   sub_8bit u_sub_hi (
      .a_i  (s1_q.a_hi),
      .nb_i (s1_q.nb_hi),
      .c_i  (s1_q.c8),
      .s_o  (hi_sum),
      .c_o  (c16_unused)
   );

   // b's sign is recovered from the stored inverted high byte
   assign raw      = {hi_sum, s1_q.lo};
   assign a15      = s1_q.a_hi[7];
   assign b15      = ~s1_q.nb_hi[7];
   assign ovfl_raw = (a15 != b15) & (raw[15] != a15);
   assign sat      = ovfl_raw ? (a15 ? SAT_NEG : SAT_POS) : raw;

   always_comb begin
      s2_valid_d = s2_valid_q;
      diff_d     = diff_q;
      flags_d    = flags_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            diff_d          = sat;
            flags_d[FLAG_V] = ovfl_raw;
            flags_d[FLAG_N] = sat[15];
            flags_d[FLAG_Z] = (sat == 16'h0000);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         diff_q     <= '0;
         flags_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         diff_q     <= diff_d;
         flags_q    <= flags_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign diff      = diff_q;
   assign ovfl      = flags_q[FLAG_V];
   assign neg       = flags_q[FLAG_N];
   assign zero      = flags_q[FLAG_Z];

endmodule
